// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_wb_stage                                                 |
// | Description : MEM/WB pipeline stage driving the integer register-file      |
// |               write port. Non-load results are written one cycle after     |
// |               acceptance. Loads park the stage in a wait state until the   |
// |               data memory returns a word, which is then byte/halfword      |
// |               aligned and sign/zero-extended. A bounded wait forces a      |
// |               completion with ERR_DATA and raises a sticky error flag.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk           in   1  clock, rising edge                                 |
// |   rst           in   1  asynchronous active-high reset                     |
// |   ex_valid      in   1  upstream presents an instruction                   |
// |   ex_reg_w      in   1  instruction writes rd                              |
// |   ex_rd_addr    in   5  destination register                               |
// |   ex_wb_sel     in   2  00 ALU, 01 load, 10 PC+4, 11 ALU                   |
// |   ex_alu_result in  32  ALU result / load byte address                     |
// |   ex_pc4        in  32  link value                                         |
// |   ex_funct3     in   3  load size and signedness                           |
// |   dm_rvalid     in   1  read data valid pulse                              |
// |   dm_rdata      in  32  word-aligned read data                             |
// |   mem_stall     out  1  upstream must hold                                 |
// |   reg_w         out  1  register-file write enable pulse                   |
// |   rd_addr       out  5  register-file write address                        |
// |   wd            out 32  register-file write data                           |
// |   load_err      out  1  sticky load-timeout flag                           |
// +----------------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_w,
  input  logic [4:0]  ex_rd_addr,
  input  logic [1:0]  ex_wb_sel,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc4,
  input  logic [2:0]  ex_funct3,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        reg_w,
  output logic [4:0]  rd_addr,
  output logic [31:0] wd,
  output logic        load_err
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  // Counter only needs to reach TIMEOUT-1; TIMEOUT of 0 or 1 still gets a 1-bit counter.
  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             state_q,    state_d;
  logic [c_cnt_w-1:0] cnt_q,      cnt_d;
  logic               reg_w_q,    reg_w_d;
  logic [4:0]         rd_addr_q,  rd_addr_d;
  logic [31:0]        wd_q,       wd_d;
  logic               load_err_q, load_err_d;
  // Pending-load context captured on acceptance.
  logic [4:0]         ld_rd_q,    ld_rd_d;
  logic               ld_we_q,    ld_we_d;
  logic [2:0]         ld_f3_q,    ld_f3_d;
  logic [1:0]         ld_off_q,   ld_off_d;

  logic [7:0]         w_ld_byte;
  logic [15:0]        w_ld_half;
  logic [31:0]        w_ld_data;
  logic               w_timeout;

  // Load data alignment and extension. Halfwords use addr[1] only.
  always_comb begin
    w_ld_byte = dm_rdata[7:0];
    case (ld_off_q)
      2'd1:    w_ld_byte = dm_rdata[15:8];
      2'd2:    w_ld_byte = dm_rdata[23:16];
      2'd3:    w_ld_byte = dm_rdata[31:24];
      default: w_ld_byte = dm_rdata[7:0];
    endcase
    w_ld_half = ld_off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ld_f3_q)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'h0, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'h0, w_ld_half};
      default: w_ld_data = dm_rdata;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (cnt_q == c_cnt_last);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reg_w_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    wd_d       = wd_q;
    load_err_d = load_err_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ex_valid) begin
          if (ex_wb_sel == 2'b01) begin
            ld_rd_d  = ex_rd_addr;
            ld_we_d  = ex_reg_w;
            ld_f3_d  = ex_funct3;
            ld_off_d = ex_alu_result[1:0];
            state_d  = S_WAIT_LOAD;
          end else begin
            reg_w_d   = ex_reg_w && (ex_rd_addr != 5'd0);
            rd_addr_d = ex_rd_addr;
            wd_d      = (ex_wb_sel == 2'b10) ? ex_pc4 : ex_alu_result;
          end
        end
      end
      S_WAIT_LOAD: begin
        // Real data takes priority over a coincident timeout.
        if (dm_rvalid) begin
          reg_w_d   = ld_we_q && (ld_rd_q != 5'd0);
          rd_addr_d = ld_rd_q;
          wd_d      = w_ld_data;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (w_timeout) begin
          reg_w_d    = ld_we_q && (ld_rd_q != 5'd0);
          rd_addr_d  = ld_rd_q;
          wd_d       = ERR_DATA;
          load_err_d = 1'b1;
          state_d    = S_IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      reg_w_q    <= 1'b0;
      rd_addr_q  <= 5'd0;
      wd_q       <= 32'd0;
      load_err_q <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= 3'd0;
      ld_off_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reg_w_q    <= reg_w_d;
      rd_addr_q  <= rd_addr_d;
      wd_q       <= wd_d;
      load_err_q <= load_err_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
    end
  end

  assign mem_stall = (state_q == S_WAIT_LOAD);
  assign reg_w     = reg_w_q;
  assign rd_addr   = rd_addr_q;
  assign wd        = wd_q;
  assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_wb_stage                                              |
// | Description : Self-checking bench for mem_wb_stage: directed scenarios     |
// |               with literal expectations, then randomized traffic compared  |
// |               every cycle against a transaction-level reference model.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_wb_stage;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_reg_w = 1'b0;
  logic [4:0]  ex_rd_addr = 5'd0;
  logic [1:0]  ex_wb_sel = 2'd0;
  logic [31:0] ex_alu_result = 32'd0;
  logic [31:0] ex_pc4 = 32'd0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        mem_stall;
  logic        reg_w;
  logic [4:0]  rd_addr;
  logic [31:0] wd;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_reg_w      (ex_reg_w),
    .ex_rd_addr    (ex_rd_addr),
    .ex_wb_sel     (ex_wb_sel),
    .ex_alu_result (ex_alu_result),
    .ex_pc4        (ex_pc4),
    .ex_funct3     (ex_funct3),
    .dm_rvalid     (dm_rvalid),
    .dm_rdata      (dm_rdata),
    .mem_stall     (mem_stall),
    .reg_w         (reg_w),
    .rd_addr       (rd_addr),
    .wd            (wd),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load extraction from arithmetic on the word: shift, mask, then extend.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    longint v;
    int     sh;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      sh = 8 * int'(off);
      v  = longint'((w >> sh) & 32'hFF);
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      sh = (int'(off) >= 2) ? 16 : 0;
      v  = longint'((w >> sh) & 32'hFFFF);
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  // Reference model: one pending load at most, tracked by its stall-cycle number.
  logic        m_busy   = 1'b0;
  int          m_waited = 0;
  logic [4:0]  m_rd     = 5'd0;
  logic        m_we     = 1'b0;
  logic [2:0]  m_f3     = 3'd0;
  logic [1:0]  m_off    = 2'd0;
  logic        e_we     = 1'b0;
  logic [4:0]  e_rd     = 5'd0;
  logic [31:0] e_wd     = 32'd0;
  logic        e_err    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_waited <= 0;
      e_we     <= 1'b0;
      e_rd     <= 5'd0;
      e_wd     <= 32'd0;
      e_err    <= 1'b0;
    end else begin
      e_we <= 1'b0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (ex_wb_sel == 2'b01) begin
            m_busy   <= 1'b1;
            m_waited <= 1;
            m_rd     <= ex_rd_addr;
            m_we     <= ex_reg_w;
            m_f3     <= ex_funct3;
            m_off    <= ex_alu_result[1:0];
          end else begin
            e_we <= ex_reg_w && (ex_rd_addr != 5'd0);
            e_rd <= ex_rd_addr;
            e_wd <= (ex_wb_sel == 2'b10) ? ex_pc4 : ex_alu_result;
          end
        end
      end else if (dm_rvalid) begin
        e_we   <= m_we && (m_rd != 5'd0);
        e_rd   <= m_rd;
        e_wd   <= extract(m_f3, m_off, dm_rdata);
        m_busy <= 1'b0;
      end else if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
        e_we   <= m_we && (m_rd != 5'd0);
        e_rd   <= m_rd;
        e_wd   <= ERR_DATA;
        e_err  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_reg_w",     {31'd0, reg_w},     {31'd0, e_we});
    chk("cyc_rd_addr",   {27'd0, rd_addr},   {27'd0, e_rd});
    chk("cyc_wd",        wd,                 e_wd);
    chk("cyc_mem_stall", {31'd0, mem_stall}, {31'd0, m_busy});
    chk("cyc_load_err",  {31'd0, load_err},  {31'd0, e_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] f3);
    ex_valid      = 1'b1;
    ex_wb_sel     = sel;
    ex_reg_w      = we;
    ex_rd_addr    = rd;
    ex_alu_result = alu;
    ex_funct3     = f3;
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    // Model self-pins.
    chk("mdl_lb",  extract(3'b000, 2'd3, 32'h80FF_7F01), 32'hFFFF_FF80);
    chk("mdl_lhu", extract(3'b101, 2'd2, 32'hBEEF_1234), 32'h0000_BEEF);
    chk("mdl_lbu", extract(3'b100, 2'd1, 32'h80FF_7F01), 32'h0000_007F);

    repeat (2) step();
    chk("rst_reg_w",     {31'd0, reg_w},     32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wd",        wd,                 32'd0);
    rst = 1'b0;
    step();

    // ALU write, one-cycle latency, single pulse.
    ex_pc4 = 32'h0000_0100;
    issue(2'b00, 1'b1, 5'd5, 32'h0000_1234, 3'd0);
    chk("alu_reg_w",   {31'd0, reg_w}, 32'd1);
    chk("alu_rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("alu_wd",      wd, 32'h0000_1234);
    step();
    chk("alu_pulse",   {31'd0, reg_w}, 32'd0);

    // LB from byte 3, data after three stall cycles.
    issue(2'b01, 1'b1, 5'd3, 32'h0000_0103, 3'b000);
    chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall2", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall3", {31'd0, mem_stall}, 32'd1);
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h80FF_7F01;
    step();
    dm_rvalid = 1'b0;
    chk("lb_wd",     wd, 32'hFFFF_FF80);
    chk("lb_reg_w",  {31'd0, reg_w}, 32'd1);
    chk("lb_unstall", {31'd0, mem_stall}, 32'd0);

    // LHU / LH upper halfword.
    issue(2'b01, 1'b1, 5'd4, 32'h0000_0202, 3'b101);
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hBEEF_1234;
    step();
    dm_rvalid = 1'b0;
    chk("lhu_wd", wd, 32'h0000_BEEF);
    issue(2'b01, 1'b1, 5'd4, 32'h0000_0202, 3'b001);
    dm_rvalid = 1'b1;
    step();
    dm_rvalid = 1'b0;
    chk("lh_wd", wd, 32'hFFFF_BEEF);

    // Timeout after TIMEOUT stall cycles.
    issue(2'b01, 1'b1, 5'd7, 32'h0000_0300, 3'b010);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_stall", {31'd0, mem_stall}, 32'd1);
      step();
    end
    chk("to_wd",      wd, ERR_DATA);
    chk("to_rd_addr", {27'd0, rd_addr}, 32'd7);
    chk("to_reg_w",   {31'd0, reg_w}, 32'd1);
    chk("to_err",     {31'd0, load_err}, 32'd1);
    step();
    step();
    chk("to_err_sticky", {31'd0, load_err}, 32'd1);

    // rd=0 never writes; stray rvalid in IDLE is ignored.
    issue(2'b00, 1'b1, 5'd0, 32'h0000_0055, 3'd0);
    chk("rd0_reg_w", {31'd0, reg_w}, 32'd0);
    chk("rd0_wd",    wd, 32'h0000_0055);
    dm_rvalid = 1'b1;
    step();
    dm_rvalid = 1'b0;
    chk("stray_reg_w", {31'd0, reg_w}, 32'd0);
    chk("stray_stall", {31'd0, mem_stall}, 32'd0);

    // Reset while a load is outstanding.
    issue(2'b01, 1'b1, 5'd9, 32'h0000_0400, 3'b010);
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_stall", {31'd0, mem_stall}, 32'd0);
    chk("rstmid_err",   {31'd0, load_err}, 32'd0);
    step();
    rst       = 1'b0;
    dm_rvalid = 1'b1;
    step();
    dm_rvalid = 1'b0;
    chk("rstmid_nowrite", {31'd0, reg_w}, 32'd0);

    // Randomized traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_reg_w      = ($urandom_range(0, 7) != 0);
      ex_rd_addr    = 5'($urandom_range(0, 31));
      ex_wb_sel     = 2'($urandom_range(0, 3));
      ex_alu_result = $urandom;
      ex_pc4        = $urandom;
      ex_funct3     = 3'($urandom_range(0, 7));
      dm_rvalid     = ($urandom_range(0, 3) == 0);
      dm_rdata      = $urandom;
      rst           = ($urandom_range(0, 249) == 0);
      step();
    end
    rst       = 1'b0;
    ex_valid  = 1'b0;
    dm_rvalid = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
